// File: rtl/q2_clock_pkg.sv
// Shared clock sequencer types for the Q2 core.
// Phase decoders import DEFAULT_PHASES from here.
package q2_clock_pkg;

  localparam int DEFAULT_PHASES = 2;
  localparam int DEFAULT_DIV_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/clock_divider.sv
// Loadable phase-length down-counter.
// zero flags the last clk of the current phase.
module clock_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] din,
  output logic                 zero
);

  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (en) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/clock_sequencer.sv
// Run/stop CPU clock and phase sequencer for Q2.
// FSM, phase counter and output registers live here.
module clock_sequencer
  import q2_clock_pkg::*;
#(
  parameter int PHASES    = DEFAULT_PHASES,
  parameter int DIV_WIDTH = DEFAULT_DIV_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 running,
  output logic                 cpu_clk,
  output logic [PHASES-1:0]    phase,
  output logic                 phase_end,
  output logic                 cycle_end
);

  localparam int PW = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);
  localparam logic [PW-1:0] HALF = PW'(PHASES / 2);

  seq_state_e    state_q;
  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_nxt;
  logic          start_pend;
  logic          active;
  logic          zero;
  logic          launch;
  logic          cont;
  logic          div_load;
  logic          div_en;

  assign active    = (state_q != ST_IDLE);
  assign phase_end = active && zero;
  assign cycle_end = phase_end && (cnt_q == LAST);
  assign cnt_nxt   = cnt_q + PW'(1);

  assign launch = (state_q == ST_IDLE) && !stop
               && (start || step);

  // A start seen any time during a step carries into run.
  assign cont = ((state_q == ST_RUN) && !stop)
             || ((state_q == ST_STEP)
                 && (start_pend || start));

  assign div_load = launch
                 || (phase_end && !cycle_end)
                 || (cycle_end && cont);
  assign div_en   = active && !zero;

  clock_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .load(div_load),
    .en  (div_en),
    .din (div),
    .zero(zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      start_pend <= 1'b0;
      running    <= 1'b0;
      cpu_clk    <= 1'b0;
      phase      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_q    <= start ? ST_RUN : ST_STEP;
            cnt_q      <= '0;
            start_pend <= 1'b0;
            running    <= 1'b1;
            cpu_clk    <= 1'b1;
            phase      <= PHASES'(1);
          end
        end
        ST_RUN, ST_STEP, ST_HALT: begin
          if (cycle_end) begin
            cnt_q      <= '0;
            start_pend <= 1'b0;
            if (cont) begin
              state_q <= ST_RUN;
              cpu_clk <= 1'b1;
              phase   <= PHASES'(1);
            end else begin
              state_q <= ST_IDLE;
              running <= 1'b0;
              cpu_clk <= 1'b0;
              phase   <= '0;
            end
          end else begin
            if (state_q == ST_RUN && stop)
              state_q <= ST_HALT;
            if (state_q == ST_STEP && start)
              start_pend <= 1'b1;
            if (phase_end) begin
              cnt_q   <= cnt_nxt;
              cpu_clk <= (cnt_nxt < HALF);
              phase   <= {phase[PHASES-2:0], 1'b0};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
